// File: rtl/pipe_rr_arb.sv
// -----------------------------------------------------------------------------
// pipe_rr_arb
//
// Round-robin arbiter in front of one shared registered valid/stall/data pipe
// stage. Each unstalled cycle it grants one valid requester, starting the
// search at the round-robin pointer and wrapping from NUM_REQ-1 to 0. The
// winner's data and index are loaded into the output register.
//
// Optional feature macro: PIPE_RR_ARB_LOCK_EN
//   When defined, a transfer with in_last==0 locks the arbiter onto that
//   requester until it sends a beat with in_last==1 (packet-atomic
//   arbitration). When undefined, in_last is ignored and every beat is
//   arbitrated independently.
//
// Parameters
//   NUM_REQ  number of requesters (2..16)
//   DW       data width per requester
//   SW       source-index width, derived as $clog2(NUM_REQ)
//
// Ports
//   clk        clock, single domain
//   arst_n     active-low reset, sampled synchronously on posedge clk
//   in_valid   per-requester valid
//   in_data    per-requester data, requester i at [i*DW +: DW]
//   in_last    per-requester end-of-packet (lock build only)
//   in_stall   per-requester stall, combinational
//   out_valid  registered output valid
//   out_data   registered output data
//   out_src    registered index of the requester that produced out_data
//   out_stall  downstream stall
// -----------------------------------------------------------------------------
module pipe_rr_arb #(
   parameter int  NUM_REQ = 4,
   parameter int  DW      = 32,
   localparam int SW      = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [NUM_REQ-1:0]    in_valid,
   input  logic [NUM_REQ*DW-1:0] in_data,
   input  logic [NUM_REQ-1:0]    in_last,
   output logic [NUM_REQ-1:0]    in_stall,
   output logic                  out_valid,
   output logic [DW-1:0]         out_data,
   output logic [SW-1:0]         out_src,
   input  logic                  out_stall
);

   logic               stage_stall;  // output register full and blocked
   logic [SW-1:0]      ptr;          // first requester to consider
   logic [NUM_REQ-1:0] elig;         // requesters allowed to compete
   logic [NUM_REQ-1:0] gnt;          // one-hot grant, zero when idle
   logic               any_gnt;
   logic [SW-1:0]      win;          // encoded grant
   logic [DW-1:0]      win_data;
   logic [SW-1:0]      ptr_next;

   assign stage_stall = out_valid & out_stall;

`ifdef PIPE_RR_ARB_LOCK_EN
   typedef enum logic {
      ARB_FREE   = 1'b0,
      ARB_LOCKED = 1'b1
   } lock_state_t;

   lock_state_t   lock_state;
   logic [SW-1:0] lock_src;

   // While locked only the owner of the open packet may compete; if it is
   // idle nobody wins and the stage loads a bubble.
   assign elig = (lock_state == ARB_LOCKED)
               ? (in_valid & (NUM_REQ'(1) << lock_src))
               : in_valid;
`else
   logic unused_last;

   assign elig        = in_valid;
   assign unused_last = ^in_last;
`endif

   // Rotating-priority search: candidate j is (ptr + j) mod NUM_REQ, the
   // first eligible candidate wins.
   always_comb begin : grant_search
      logic [SW:0]   sum;
      logic [SW-1:0] cand;
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment; otherwise the tool infers a latch.
      gnt     = '0;
      win     = '0;
      any_gnt = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         sum  = {1'b0, ptr} + (SW+1)'(j);
         cand = SW'((sum >= (SW+1)'(NUM_REQ)) ? sum - (SW+1)'(NUM_REQ) : sum);
         if (!any_gnt && elig[cand]) begin
            any_gnt   = 1'b1;
            win       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

   // AND-OR mux on the one-hot grant keeps the data path free of a wide
   // index-driven shifter.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_data |= in_data[i*DW +: DW] & {DW{gnt[i]}};
      end
   end

   assign ptr_next = (win == SW'(NUM_REQ - 1)) ? '0 : win + SW'(1);

   // A stalled stage blocks everybody; otherwise only the winner proceeds.
   assign in_stall = {NUM_REQ{stage_stall}} | ~gnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         // The output register is reset along with the control state so a
         // beat held at reset time is dropped rather than replayed.
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= '0;
         ptr        <= '0;
`ifdef PIPE_RR_ARB_LOCK_EN
         lock_state <= ARB_FREE;
         lock_src   <= '0;
`endif
      end else if (!stage_stall) begin
         out_valid <= any_gnt;
         if (any_gnt) begin
            out_data <= win_data;
            out_src  <= win;
`ifdef PIPE_RR_ARB_LOCK_EN
            if (in_last[win]) begin
               // End of packet: release and rotate past the owner.
               lock_state <= ARB_FREE;
               ptr        <= ptr_next;
            end else begin
               // Packet continues: pin the arbiter, pointer stays put.
               lock_state <= ARB_LOCKED;
               lock_src   <= win;
            end
`else
            ptr <= ptr_next;
`endif
         end
      end
   end

   // Structural sanity checks, ignored by synthesis.
   a_gnt_onehot : assert property (@(posedge clk) disable iff (!arst_n)
      $onehot0(gnt));
   a_gnt_elig : assert property (@(posedge clk) disable iff (!arst_n)
      (gnt & ~elig) == '0);

endmodule
